// File: rtl/sg_uart_rx_seq.sv
// APB master sequencer for UART receive testing: programs BAUD/CTRL, then polls
// STATUS and reads DATA for NUM_BYTES characters, checking an incrementing pattern.
module sg_uart_rx_seq #(
  parameter logic [31:0] BAUD_VAL    = 32'h0000_0020,
  parameter logic [31:0] CTRL_VAL    = 32'h0000_0026,
  parameter int unsigned NUM_BYTES   = 4,
  parameter logic [7:0]  EXP_BASE    = 8'h53,
  parameter int unsigned POLL_LIMIT  = 64,
  parameter int unsigned RXFULL_BIT  = 0,
  parameter logic [9:0]  ADDR_DATA   = 10'd0,
  parameter logic [9:0]  ADDR_STATUS = 10'd1,
  parameter logic [9:0]  ADDR_CTRL   = 10'd2,
  parameter logic [9:0]  ADDR_BAUD   = 10'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        PSEL,
  output logic [9:0]  PADDR,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        TIMEOUT,
  output logic [7:0]  ERR_CNT,
  output logic [7:0]  BYTE_CNT
);

  typedef enum logic [2:0] {
    IDLE, CFG_BAUD, GAP, CFG_CTRL, POLL, READ, FINISH
  } state_t;

  state_t      state;
  state_t      gap_next;
  logic [15:0] poll_cnt;
  logic [16:0] poll_inc;
  logic [7:0]  byte_nxt;
  logic [7:0]  err_nxt;
  logic        mismatch;
  logic        unused_prdata;

  always_comb begin
    poll_inc      = {1'b0, poll_cnt} + 17'd1;
    byte_nxt      = BYTE_CNT + 8'd1;
    mismatch      = (PRDATA[7:0] != (EXP_BASE + BYTE_CNT));
    err_nxt       = (mismatch && (ERR_CNT != 8'hFF)) ? ERR_CNT + 8'd1 : ERR_CNT;
    unused_prdata = ^PRDATA;
  end

  // PENABLE doubles as the SETUP/ACCESS phase flag of the current APB state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      gap_next <= IDLE;
      poll_cnt <= '0;
      PSEL     <= 1'b0;
      PADDR    <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      TIMEOUT  <= 1'b0;
      ERR_CNT  <= '0;
      BYTE_CNT <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (START) begin
            state    <= CFG_BAUD;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            PADDR    <= ADDR_BAUD;
            PWRITE   <= 1'b1;
            PWDATA   <= BAUD_VAL;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            TIMEOUT  <= 1'b0;
            ERR_CNT  <= '0;
            BYTE_CNT <= '0;
          end
        end
        GAP: begin
          state   <= gap_next;
          PSEL    <= 1'b1;
          PENABLE <= 1'b0;
          case (gap_next)
            CFG_CTRL: begin
              PADDR  <= ADDR_CTRL;
              PWRITE <= 1'b1;
              PWDATA <= CTRL_VAL;
            end
            READ: begin
              PADDR  <= ADDR_DATA;
              PWRITE <= 1'b0;
              PWDATA <= '0;
            end
            default: begin
              PADDR  <= ADDR_STATUS;
              PWRITE <= 1'b0;
              PWDATA <= '0;
            end
          endcase
        end
        default: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            case (state)
              CFG_BAUD: begin
                state    <= GAP;
                gap_next <= CFG_CTRL;
              end
              CFG_CTRL: begin
                state    <= GAP;
                gap_next <= POLL;
                poll_cnt <= '0;
              end
              POLL: begin
                if (PRDATA[RXFULL_BIT]) begin
                  state    <= GAP;
                  gap_next <= READ;
                end else if (poll_inc == 17'(POLL_LIMIT)) begin
                  state   <= FINISH;
                  TIMEOUT <= 1'b1;
                  DONE    <= 1'b1;
                  PASS    <= 1'b0;
                  BUSY    <= 1'b0;
                end else begin
                  poll_cnt <= poll_inc[15:0];
                  state    <= GAP;
                  gap_next <= POLL;
                end
              end
              READ: begin
                ERR_CNT  <= err_nxt;
                BYTE_CNT <= byte_nxt;
                poll_cnt <= '0;
                if (byte_nxt == 8'(NUM_BYTES)) begin
                  state <= FINISH;
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  PASS  <= (err_nxt == 8'd0) && !TIMEOUT;
                end else begin
                  state    <= GAP;
                  gap_next <= POLL;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
